// File: rtl/dram_controller_pkg.sv
// Shared geometry for the DRAM line controller: address/beat/line widths and
// the line type viewed as an array of bursts beats.
package dram_controller_pkg;

    localparam int ADDRESS_LEN        = 16;
    localparam int BURST_ACCESS_WIDTH = 32;
    localparam int BURST_LEN          = 4;
    localparam int ROW_WIDTH          = BURST_LEN * BURST_ACCESS_WIDTH;

    localparam int BEAT_IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BEAT_CNT_W = $clog2(BURST_LEN + 1);

    typedef logic [ADDRESS_LEN-1:0]                        addr_t;
    typedef logic [BURST_ACCESS_WIDTH-1:0]                 beat_t;
    typedef logic [BURST_LEN-1:0][BURST_ACCESS_WIDTH-1:0]  line_t;
    typedef logic [BEAT_CNT_W-1:0]                         beat_cnt_t;

endpackage

// File: rtl/dram_controller.sv
// Line-wide host request/response front end for a burst-oriented DRAM port:
// one line per transaction, split into BURST_LEN beats, with a burst timeout.
module dram_controller
    import dram_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDRESS_LEN-1:0] req_addr,
    input  logic [ROW_WIDTH-1:0]   req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ROW_WIDTH-1:0]   resp_rdata,
    output logic                   resp_err,
    output logic [ADDRESS_LEN-1:0] addr,
    output logic                   read_en,
    output logic                   write_en,
    output logic [BURST_ACCESS_WIDTH-1:0] wdata,
    input  logic                   dram_ready,
    input  logic                   dram_complete,
    input  logic [BURST_ACCESS_WIDTH-1:0] rdata,
    input  logic                   valid
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WAIT_READY, READ, WRITE, RESP} state_t;

    state_t           r_state, w_state_next;
    logic             r_we;
    addr_t            r_addr;
    line_t            r_line;
    beat_cnt_t        r_cnt;
    logic [TMR_W-1:0] r_timer;
    logic             r_read_en, r_write_en;
    logic             r_resp_valid, r_resp_err;
    line_t            r_resp_rdata;

    logic                  w_in_burst, w_beat, w_timeout, w_exit;
    logic [BEAT_IDX_W-1:0] w_slot;
    beat_cnt_t             w_cnt_next;
    line_t                 w_line_next;

    assign w_in_burst = (r_state == READ) || (r_state == WRITE);
    assign w_slot     = r_cnt[BEAT_IDX_W-1:0];
    assign w_beat     = w_in_burst && valid && (r_cnt != BEAT_CNT_W'(BURST_LEN));
    assign w_timeout  = w_in_burst && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_exit     = w_in_burst && (dram_complete || w_timeout);

    // Beat accounting including the current cycle, so a beat that lands in the
    // same cycle as dram_complete still counts toward the line and the error check.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_cnt_next  = r_cnt;
        w_line_next = r_line;
        if (w_beat) begin
            w_cnt_next = r_cnt + 1'b1;
            if (r_state == READ) w_line_next[w_slot] = rdata;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:       if (req_valid)  w_state_next = WAIT_READY;
            WAIT_READY: if (dram_ready) w_state_next = r_we ? WRITE : READ;
            READ,
            WRITE:      if (w_exit)     w_state_next = RESP;
            RESP:       if (resp_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // NOTE: the line buffer is a plain register rather than a RAM, so it is cleared by reset like any other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_line       <= '0;
            r_cnt        <= '0;
            r_timer      <= '0;
            r_read_en    <= 1'b0;
            r_write_en   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            // Reads start from a clean line so missing beats never leak old data.
            if (r_state == IDLE && req_valid) begin
                r_we   <= req_we;
                r_addr <= req_addr;
                r_line <= req_we ? line_t'(req_wdata) : '0;
            end
            if (r_state == WAIT_READY && dram_ready) begin
                r_read_en  <= !r_we;
                r_write_en <= r_we;
                r_cnt      <= '0;
                r_timer    <= '0;
            end
            if (w_in_burst) begin
                r_cnt   <= w_cnt_next;
                r_line  <= w_line_next;
                r_timer <= r_timer + 1'b1;
            end
            if (w_exit) begin
                r_read_en    <= 1'b0;
                r_write_en   <= 1'b0;
                r_resp_valid <= 1'b1;
                r_resp_err   <= !dram_complete || (w_cnt_next != BEAT_CNT_W'(BURST_LEN));
                r_resp_rdata <= (dram_complete && !r_we) ? w_line_next : '0;
            end
            if (r_state == RESP && resp_ready) begin
                r_resp_valid <= 1'b0;
                r_resp_err   <= 1'b0;
                r_resp_rdata <= '0;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign addr       = r_addr;
    assign read_en    = r_read_en;
    assign write_en   = r_write_en;
    assign wdata      = (r_state == WRITE && r_cnt != BEAT_CNT_W'(BURST_LEN)) ? r_line[w_slot] : '0;

endmodule

// File: tb/tb_dram_controller.sv
// Scoreboard bench for dram_controller: expected responses are queued as
// requests are issued and compared when the controller answers.
module tb_dram_controller;
    import dram_controller_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    addr_t       req_addr, addr;
    logic [ROW_WIDTH-1:0] req_wdata, resp_rdata;
    logic        resp_valid, resp_ready, resp_err;
    logic        read_en, write_en;
    beat_t       wdata, rdata;
    logic        dram_ready, dram_complete, valid;

    typedef struct {
        line_t rdata;
        line_t mask;
        logic  err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    dram_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .addr(addr), .read_en(read_en), .write_en(write_en), .wdata(wdata),
        .dram_ready(dram_ready), .dram_complete(dram_complete),
        .rdata(rdata), .valid(valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input line_t d, input line_t m, input logic e);
        exp_t x;
        x.rdata = d;
        x.mask  = m;
        x.err   = e;
        sb.push_back(x);
    endtask

    task automatic send_req(input logic we, input addr_t a, input line_t d);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL send_req_ready: got %b want 1", req_ready);
        else n_pass++;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drive_beats(input beat_t b[4], input int n);
        for (int k = 0; k < n; k++) begin
            valid = 1'b1;
            rdata = b[k];
            tick();
        end
        valid = 1'b0;
        rdata = '0;
    endtask

    task automatic finish_burst();
        dram_complete = 1'b1;
        tick();
        dram_complete = 1'b0;
    endtask

    task automatic collect_resp(input string name);
        exp_t e;
        int   n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (resp_valid !== 1'b1) $display("FAIL %s_resp_valid: got %b want 1", name, resp_valid);
        else n_pass++;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s_scoreboard: got empty want entry", name);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ((resp_rdata & e.mask) !== (e.rdata & e.mask))
                $display("FAIL %s_rdata: got %h want %h", name, resp_rdata & e.mask, e.rdata & e.mask);
            else n_pass++;
            n_checks++;
            if (resp_err !== e.err) $display("FAIL %s_err: got %b want %b", name, resp_err, e.err);
            else n_pass++;
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL %s_release: got valid=%b ready=%b want valid=0 ready=1", name, resp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (read_en !== 1'b0 || write_en !== 1'b0)
            $display("FAIL reset_enables: got rd=%b wr=%b want 0 0", read_en, write_en);
        else n_pass++;
        n_checks++;
        if (addr !== '0 || wdata !== '0) $display("FAIL reset_addr_wdata: got %h %h want 0 0", addr, wdata);
        else n_pass++;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== '0)
            $display("FAIL reset_resp: got v=%b e=%b d=%h want 0", resp_valid, resp_err, resp_rdata);
        else n_pass++;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready);
        else n_pass++;
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

    task automatic test_read();
        beat_t b[4] = '{32'd11, 32'd22, 32'd33, 32'd44};
        push_exp({32'd44, 32'd33, 32'd22, 32'd11}, '1, 1'b0);
        dram_ready = 1'b1;
        send_req(1'b0, addr_t'(5), '0);
        n_checks++;
        if (read_en !== 1'b0) $display("FAIL read_latency_early: got %b want 0", read_en);
        else n_pass++;
        tick();
        n_checks++;
        if (read_en !== 1'b1 || write_en !== 1'b0 || addr !== addr_t'(5))
            $display("FAIL read_enable: got rd=%b wr=%b addr=%h want 1 0 5", read_en, write_en, addr);
        else n_pass++;
        drive_beats(b, 4);
        finish_burst();
        n_checks++;
        if (read_en !== 1'b0 || resp_valid !== 1'b1)
            $display("FAIL read_complete: got rd=%b rv=%b want 0 1", read_en, resp_valid);
        else n_pass++;
        collect_resp("read");
    endtask

    task automatic test_write();
        beat_t w[4] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        push_exp('0, '1, 1'b0);
        send_req(1'b1, addr_t'(3), {w[3], w[2], w[1], w[0]});
        tick();
        n_checks++;
        if (write_en !== 1'b1 || read_en !== 1'b0 || addr !== addr_t'(3))
            $display("FAIL write_enable: got wr=%b rd=%b addr=%h want 1 0 3", write_en, read_en, addr);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (wdata !== w[k]) $display("FAIL write_beat%0d: got %h want %h", k, wdata, w[k]);
            else n_pass++;
            valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        n_checks++;
        if (wdata !== '0 || write_en !== 1'b1)
            $display("FAIL write_saturate: got wdata=%h wr=%b want 0 1", wdata, write_en);
        else n_pass++;
        finish_burst();
        n_checks++;
        if (write_en !== 1'b0 || resp_valid !== 1'b1)
            $display("FAIL write_complete: got wr=%b rv=%b want 0 1", write_en, resp_valid);
        else n_pass++;
        collect_resp("write");
    endtask

    task automatic test_wait_ready();
        beat_t b[4] = '{32'd5, 32'd6, 32'd7, 32'd8};
        int    seen = 0;
        push_exp({32'd8, 32'd7, 32'd6, 32'd5}, '1, 1'b0);
        dram_ready = 1'b0;
        send_req(1'b0, addr_t'(9), '0);
        repeat (10) begin
            if (read_en !== 1'b0 || write_en !== 1'b0) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) $display("FAIL wait_no_enable: got %0d enabled cycles want 0", seen);
        else n_pass++;
        dram_ready = 1'b1;
        tick();
        n_checks++;
        if (read_en !== 1'b1) $display("FAIL wait_enable_rise: got %b want 1", read_en);
        else n_pass++;
        drive_beats(b, 4);
        finish_burst();
        collect_resp("wait_ready");
    endtask

    task automatic test_timeout();
        int n = 0;
        push_exp('0, '1, 1'b1);
        send_req(1'b0, addr_t'(7), '0);
        tick();
        while (read_en === 1'b1 && n < 40) begin
            valid = (n < 4);
            rdata = beat_t'(100 + n);
            n++;
            tick();
        end
        valid = 1'b0;
        rdata = '0;
        n_checks++;
        if (n != TO) $display("FAIL timeout_cycles: got %0d want %0d", n, TO);
        else n_pass++;
        collect_resp("timeout");
    endtask

    task automatic test_short_backpressure();
        beat_t b[4] = '{32'd11, 32'd22, 32'd33, 32'd44};
        line_t exp_d = {32'd0, 32'd33, 32'd22, 32'd11};
        line_t m     = {32'd0, {96{1'b1}}};
        int    bad_v = 0, bad_d = 0, bad_e = 0, bad_r = 0;
        push_exp(exp_d, m, 1'b1);
        send_req(1'b0, addr_t'(12), '0);
        tick();
        drive_beats(b, 3);
        finish_burst();
        repeat (5) begin
            if (resp_valid !== 1'b1) bad_v++;
            if ((resp_rdata & m) !== exp_d) bad_d++;
            if (resp_err !== 1'b1) bad_e++;
            if (req_ready !== 1'b0) bad_r++;
            tick();
        end
        n_checks++;
        if (bad_v != 0) $display("FAIL hold_valid: got %0d drops want 0", bad_v);
        else n_pass++;
        n_checks++;
        if (bad_d != 0 || bad_e != 0)
            $display("FAIL hold_payload: got %0d/%0d bad cycles want 0/0", bad_d, bad_e);
        else n_pass++;
        n_checks++;
        if (bad_r != 0) $display("FAIL hold_req_ready: got %0d ready cycles want 0", bad_r);
        else n_pass++;
        collect_resp("short_burst");
    endtask

    task automatic test_reset_mid_write();
        int seen = 0;
        push_exp('0, '1, 1'b0);
        send_req(1'b1, addr_t'(21), {32'd4, 32'd3, 32'd2, 32'd1});
        tick();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        n_checks++;
        if (write_en !== 1'b1) $display("FAIL midrst_pre: got %b want 1", write_en);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (write_en !== 1'b0 || wdata !== '0 || req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL midrst_drop: got wr=%b wd=%h rr=%b rv=%b want 0 0 1 0",
                     write_en, wdata, req_ready, resp_valid);
        else n_pass++;
        sb.delete();
        tick();
        tick();
        @(negedge clk) rst = 1'b1;
        repeat (5) begin
            tick();
            if (resp_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL midrst_no_resp: got %0d resp cycles want 0", seen);
        else n_pass++;
    endtask

    task automatic test_ignore_idle();
        int seen = 0;
        valid         = 1'b1;
        dram_complete = 1'b1;
        repeat (3) begin
            tick();
            if (resp_valid !== 1'b0 || read_en !== 1'b0 || write_en !== 1'b0) seen++;
        end
        valid         = 1'b0;
        dram_complete = 1'b0;
        n_checks++;
        if (seen != 0) $display("FAIL idle_ignore: got %0d reacting cycles want 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        beat_t w[4] = '{32'h1234_0000, 32'h1234_0001, 32'h1234_0002, 32'h1234_0003};
        beat_t r[4] = '{32'hFEED_0010, 32'hFEED_0020, 32'hFEED_0030, 32'hFEED_0040};
        push_exp('0, '1, 1'b0);
        push_exp({r[3], r[2], r[1], r[0]}, '1, 1'b0);
        send_req(1'b1, addr_t'(40), {w[3], w[2], w[1], w[0]});
        tick();
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL b2b_busy_ready: got %b want 0", req_ready);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (wdata !== w[k]) $display("FAIL b2b_wbeat%0d: got %h want %h", k, wdata, w[k]);
            else n_pass++;
            valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        finish_burst();
        collect_resp("b2b_write");
        send_req(1'b0, addr_t'(41), '0);
        tick();
        drive_beats(r, 4);
        finish_burst();
        collect_resp("b2b_read");
    endtask

    initial begin
        rst           = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        resp_ready    = 1'b0;
        dram_ready    = 1'b1;
        dram_complete = 1'b0;
        rdata         = '0;
        valid         = 1'b0;

        test_reset();
        test_read();
        test_write();
        test_wait_ready();
        test_timeout();
        test_short_backpressure();
        test_reset_mid_write();
        test_ignore_idle();
        test_back_to_back();

        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dram_controller.md
DRAM_CONTROLLER -- requirements
Module: dram_controller

Interface
REQ-001 SHALL take parameter TIMEOUT_CYCLES, default 1024: cycles allowed from enable assertion to dram_complete.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk is the single clock; rst is the asynchronous active-low reset.
REQ-003 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  controller accepts request
- req_we  in  1  1=line write, 0=line read
- req_addr  in  ADDRESS_LEN  row address
- req_wdata  in  ROW_WIDTH  write line
- resp_valid  out  1  response present
- resp_ready  in  1  host accepts response
- resp_rdata  out  ROW_WIDTH  read line (zero for writes)
- resp_err  out  1  timeout or beat-count error
- addr  out  ADDRESS_LEN  memory address
- read_en  out  1  memory read request
- write_en  out  1  memory write request
- wdata  out  BURST_ACCESS_WIDTH  current write beat
- dram_ready  in  1  memory idle
- dram_complete  in  1  burst finished
- rdata  in  BURST_ACCESS_WIDTH  read beat
- valid  in  1  beat strobe

Function
REQ-004 FSM states SHALL be IDLE, WAIT_READY, READ, WRITE, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both high, latching req_we, req_addr and req_wdata, then moving to WAIT_READY.
REQ-006 WAIT_READY SHALL move to READ or WRITE, according to the latched req_we, on the first cycle dram_ready=1.
REQ-007 In READ/WRITE, read_en/write_en SHALL be registered high and addr held stable until exit; exactly one of read_en/write_en SHALL be high at any time.
REQ-008 Beat k SHALL map to line bits [(k+1)*BURST_ACCESS_WIDTH-1 : k*BURST_ACCESS_WIDTH]; a beat counter SHALL reset to 0 on entering READ/WRITE.
REQ-009 READ: each cycle valid=1 with counter<BURST_LEN SHALL store rdata into beat slot[counter] and increment the counter; valid beats beyond BURST_LEN SHALL be ignored and the counter SHALL saturate at BURST_LEN.
REQ-010 WRITE: wdata SHALL combinationally present the latched line slot[counter], or 0 when counter=BURST_LEN; the counter SHALL increment on each valid and saturate at BURST_LEN.
REQ-011 dram_complete=1 in READ/WRITE SHALL deassert the enables on the next edge and move to RESP; resp_err SHALL be set if the counter is not BURST_LEN.
REQ-012 A timeout counter SHALL run from entry to READ/WRITE; on reaching TIMEOUT_CYCLES without dram_complete, the block SHALL deassert the enables, move to RESP with resp_err=1, and zero resp_rdata.
REQ-013 RESP: resp_valid SHALL be 1 and resp_rdata/resp_err held until resp_ready=1, then the block SHALL return to IDLE. A write SHALL return resp_rdata=0.
REQ-014 dram_complete or valid outside READ/WRITE SHALL be ignored.
REQ-015 Minimum latency SHALL be: acceptance -> enables high in 2 cycles when dram_ready=1; dram_complete -> resp_valid in 1 cycle.
REQ-016 Back-to-back requests SHALL be accepted only in IDLE, so there is no overlap.

Reset
REQ-017 While rst=0, state SHALL be IDLE and the following SHALL be 0: read_en, write_en, addr, resp_valid, resp_err, resp_rdata, the beat counter, the timeout counter and the latched line; wdata=0 and req_ready=1.
REQ-018 Reset mid-burst SHALL drop the enables immediately (asynchronous) and discard the transaction, with no response issued.

Structure
REQ-019 ADDRESS_LEN, BURST_ACCESS_WIDTH, BURST_LEN and ROW_WIDTH SHALL come from package types; the state enum SHALL be local.
REQ-020 The block SHALL be a single module with no sub-modules; the line buffer SHALL be a ROW_WIDTH register written by beat slot.

Verification (package BURST_LEN=4, BURST_ACCESS_WIDTH=32)
REQ-021 Read, addr=5; memory returns beats 11,22,33,44 then dram_complete -> resp_rdata={44,33,22,11}, resp_err=0, read_en low the cycle after dram_complete.
REQ-022 Write, addr=3, line={D,C,B,A} -> wdata shows A,B,C,D on successive valid cycles; write_en held until dram_complete; resp_valid=1, resp_err=0.
REQ-023 dram_ready held 0 for 10 cycles after acceptance -> no enable asserted; enable rises 1 cycle after dram_ready=1.
REQ-024 Memory never completes, TIMEOUT_CYCLES=16 -> enable drops after 16 cycles; resp_err=1, resp_rdata=0.
REQ-025 Read with only 3 valid beats before dram_complete -> resp_err=1; resp_ready held 0 for 5 cycles -> response stable, req_ready=0.
REQ-026 rst=0 asserted during a write burst -> write_en=0 immediately, no resp_valid, next request served normally.
